// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: tag RAM front-end with invalidation sweep, tag updates and pipelined lookups.
// Define DCACHE_TAG_PARITY_EN to store and check even parity in bit TAG_WIDTH+2.
module dcache_tag_ctrl #(
    parameter int SET_WIDTH  = 7,
    parameter int TAG_WIDTH  = 20,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  busy,
    input  logic                  lkp_req,
    output logic                  lkp_ready,
    input  logic [SET_WIDTH-1:0]  lkp_set,
    input  logic [TAG_WIDTH-1:0]  lkp_tag,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_dirty,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  upd_req,
    input  logic [SET_WIDTH-1:0]  upd_set,
    input  logic [TAG_WIDTH-1:0]  upd_tag,
    input  logic                  upd_valid,
    input  logic                  upd_dirty,
    output logic                  par_err,
    output logic                  ram_req,
    output logic [NUM_COL-1:0]    ram_wr_en,
    output logic [SET_WIDTH-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    typedef enum logic {SWEEP, IDLE} state_e;
    state_e                 state_q, state_d;
    logic [SET_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   idle, wr_upd, lkp_fire, par_w, par_bad;
    logic [TAG_WIDTH+1:0]   upd_ent;
    logic                   unused_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SWEEP) begin
            cnt_d   = cnt_q + SET_WIDTH'(1);
            state_d = &cnt_q ? IDLE : SWEEP;
        end else if (flush_req) begin
            cnt_d   = '0;
            state_d = SWEEP;
        end
        pend_d = lkp_fire;
        tag_d  = lkp_fire ? lkp_tag : tag_q;
    end

    always_comb begin
        idle      = state_q == IDLE;
        busy      = !idle;
        wr_upd    = idle & !flush_req & upd_req;
        lkp_ready = idle & !flush_req & !upd_req;
        lkp_fire  = lkp_ready & lkp_req;
        upd_ent   = {upd_dirty, upd_valid, upd_tag};
`ifdef DCACHE_TAG_PARITY_EN
        par_w     = ^upd_ent;
        par_bad   = ^ram_rdata[TAG_WIDTH+2:0];
`else
        par_w     = 1'b0;
        par_bad   = 1'b0;
`endif
        ram_req   = !idle | wr_upd | lkp_fire;
        ram_wr_en = (!idle | wr_upd) ? '1 : '0;
        ram_addr  = !idle ? cnt_q : upd_req ? upd_set : lkp_set;
        ram_wdata = wr_upd ? DATA_WIDTH'({par_w, upd_ent}) : '0;
        // The RAM returns the data one cycle after the accepted lookup.
        rsp_valid = pend_q;
        rsp_hit   = pend_q & ram_rdata[TAG_WIDTH] & (ram_rdata[TAG_WIDTH-1:0] == tag_q) & !par_bad;
        rsp_dirty = pend_q & ram_rdata[TAG_WIDTH+1];
        rsp_tag   = pend_q ? ram_rdata[TAG_WIDTH-1:0] : '0;
        par_err   = pend_q & par_bad;
        unused_rdata = ^ram_rdata;
    end
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb_dcache_tag_ctrl: directed vectors and random traffic against a set-array model of the tag store.
module tb_dcache_tag_ctrl;
    localparam int SETS = 128;
`ifdef DCACHE_TAG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_req, busy, lkp_req, lkp_ready, rsp_valid, rsp_hit, rsp_dirty;
    logic [6:0]  lkp_set, upd_set, ram_addr;
    logic [19:0] lkp_tag, rsp_tag, upd_tag;
    logic        upd_req, upd_valid, upd_dirty, par_err, ram_req;
    logic [3:0]  ram_wr_en;
    logic [31:0] ram_wdata, ram_rdata, rdata_q, flip;
    logic [31:0] mem [SETS];

    int vectors = 0, miscompares = 0;

    // Reference: per-set entries, remaining sweep cycles and the outstanding lookup.
    bit          rv [SETS];
    bit          rd [SETS];
    logic [19:0] rt [SETS];
    int          sweep_left;
    bit          pend;
    logic [6:0]  p_set;
    logic [19:0] p_tag;
    bit          tc, teh, ted;
    logic [19:0] tet;

    typedef struct {
        bit upd; logic [6:0] uset; logic [19:0] utag; bit uv, ud;
        bit lkp; logic [6:0] lset; logic [19:0] ltag;
        bit c, eh, ed; logic [19:0] et;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    dcache_tag_ctrl dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .busy(busy),
        .lkp_req(lkp_req), .lkp_ready(lkp_ready), .lkp_set(lkp_set), .lkp_tag(lkp_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty), .rsp_tag(rsp_tag),
        .upd_req(upd_req), .upd_set(upd_set), .upd_tag(upd_tag), .upd_valid(upd_valid),
        .upd_dirty(upd_dirty), .par_err(par_err), .ram_req(ram_req), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_req) begin
            for (int c = 0; c < 4; c++)
                if (ram_wr_en[c]) mem[ram_addr][c*8 +: 8] <= ram_wdata[c*8 +: 8];
            if (ram_wr_en == 4'h0) rdata_q <= mem[ram_addr];
        end
    end
    assign ram_rdata = rdata_q ^ flip;

    function automatic logic [31:0] word(input bit v, input bit d, input logic [19:0] t);
        return {9'b0, PAR ? ^{d, v, t} : 1'b0, d, v, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < SETS; s++) begin
            rv[s] = 0; rd[s] = 0; rt[s] = '0;
        end
        sweep_left = SETS;
        pend = 0;
    endtask

    task automatic tick();
        logic [31:0] w;
        bit bad;
        @(negedge clk);
        chk("busy", busy, sweep_left > 0);
        if (sweep_left > 0) begin
            chk("sw_ready", lkp_ready, 0);
            chk("sw_req", ram_req, 1);
            chk("sw_wr_en", ram_wr_en, 4'hF);
            chk("sw_addr", ram_addr, SETS - sweep_left);
            chk("sw_wdata", ram_wdata, 0);
        end else if (!flush_req) begin
            chk("lkp_ready", lkp_ready, !upd_req);
            if (upd_req) begin
                chk("upd_req", ram_req, 1);
                chk("upd_wr_en", ram_wr_en, 4'hF);
                chk("upd_addr", ram_addr, upd_set);
                chk("upd_wdata", ram_wdata, word(upd_valid, upd_dirty, upd_tag));
            end else begin
                chk("lkp_ram_req", ram_req, lkp_req);
                chk("lkp_wr_en", ram_wr_en, 0);
                if (lkp_req) chk("lkp_addr", ram_addr, lkp_set);
            end
        end
        w = pend ? word(rv[p_set], rd[p_set], rt[p_set]) ^ flip : 0;
        bad = PAR && pend && ^w[22:0];
        chk("rsp_valid", rsp_valid, pend);
        chk("rsp_hit", rsp_hit, pend && w[20] && w[19:0] == p_tag && !bad);
        chk("rsp_dirty", rsp_dirty, w[21]);
        chk("rsp_tag", rsp_tag, w[19:0]);
        chk("par_err", par_err, bad);
        if (tc) begin
            chk("tbl_valid", rsp_valid, 1);
            chk("tbl_hit", rsp_hit, teh);
            chk("tbl_dirty", rsp_dirty, ted);
            chk("tbl_tag", rsp_tag, tet);
        end
        @(posedge clk);
        if (rst) clear_model();
        else if (sweep_left > 0) begin
            sweep_left--;
            pend = 0;
        end else if (flush_req) clear_model();
        else if (upd_req) begin
            rv[upd_set] = upd_valid; rd[upd_set] = upd_dirty; rt[upd_set] = upd_tag;
            pend = 0;
        end else begin
            pend = lkp_req; p_set = lkp_set; p_tag = lkp_tag;
        end
        #1;
    endtask

    task automatic quiet();
        rst = 0; flush_req = 0; upd_req = 0; lkp_req = 0; tc = 0;
    endtask

    task automatic lookup(input logic [6:0] s, input logic [19:0] t);
        quiet(); lkp_req = 1; lkp_set = s; lkp_tag = t; tick();
    endtask

    initial begin
        tbl[0]  = '{1, 5,   20'hABCDE, 1, 1, 0, 0,   20'h0,     0, 0, 0, 20'h0};
        tbl[1]  = '{0, 0,   20'h0,     0, 0, 1, 5,   20'hABCDE, 0, 0, 0, 20'h0};
        tbl[2]  = '{0, 0,   20'h0,     0, 0, 1, 5,   20'h12345, 1, 1, 1, 20'hABCDE};
        tbl[3]  = '{1, 9,   20'h11111, 1, 0, 1, 9,   20'h11111, 1, 0, 1, 20'hABCDE};
        tbl[4]  = '{0, 0,   20'h0,     0, 0, 1, 9,   20'h11111, 0, 0, 0, 20'h0};
        tbl[5]  = '{1, 9,   20'h22222, 1, 1, 0, 0,   20'h0,     1, 1, 0, 20'h11111};
        tbl[6]  = '{0, 0,   20'h0,     0, 0, 1, 9,   20'h22222, 0, 0, 0, 20'h0};
        tbl[7]  = '{0, 0,   20'h0,     0, 0, 0, 0,   20'h0,     1, 1, 1, 20'h22222};
        tbl[8]  = '{1, 0,   20'h00001, 1, 0, 0, 0,   20'h0,     0, 0, 0, 20'h0};
        tbl[9]  = '{1, 127, 20'hFFFFF, 1, 1, 0, 0,   20'h0,     0, 0, 0, 20'h0};
        tbl[10] = '{0, 0,   20'h0,     0, 0, 1, 0,   20'h00001, 0, 0, 0, 20'h0};
        tbl[11] = '{0, 0,   20'h0,     0, 0, 1, 127, 20'hFFFFF, 1, 1, 0, 20'h00001};
        tbl[12] = '{0, 0,   20'h0,     0, 0, 0, 0,   20'h0,     1, 1, 1, 20'hFFFFF};
        tbl[13] = '{1, 3,   20'h77777, 0, 1, 0, 0,   20'h0,     0, 0, 0, 20'h0};
        tbl[14] = '{0, 0,   20'h0,     0, 0, 1, 3,   20'h77777, 0, 0, 0, 20'h0};
        tbl[15] = '{0, 0,   20'h0,     0, 0, 0, 0,   20'h0,     1, 0, 1, 20'h77777};

        quiet(); flip = 0;
        lkp_set = 0; lkp_tag = 0; upd_set = 0; upd_tag = 0; upd_valid = 0; upd_dirty = 0;
        rst = 1;
        @(posedge clk); #1;
        clear_model();
        tick();
        rst = 0;
        // Requests during the sweep must be dropped.
        for (int i = 0; i < SETS; i++) begin
            upd_req = $urandom_range(0, 1); flush_req = $urandom_range(0, 1);
            lkp_req = $urandom_range(0, 1);
            upd_set = 7'($urandom); upd_tag = 20'($urandom); upd_valid = 1; upd_dirty = 1;
            lkp_set = upd_set; lkp_tag = upd_tag;
            tick();
        end
        quiet(); tick();

        foreach (tbl[i]) begin
            upd_req = tbl[i].upd; upd_set = tbl[i].uset; upd_tag = tbl[i].utag;
            upd_valid = tbl[i].uv; upd_dirty = tbl[i].ud;
            lkp_req = tbl[i].lkp; lkp_set = tbl[i].lset; lkp_tag = tbl[i].ltag;
            tc = tbl[i].c; teh = tbl[i].eh; ted = tbl[i].ed; tet = tbl[i].et;
            tick();
        end
        quiet();

        // Corrupted read data: a flipped tag bit and a flipped parity bit.
        lookup(5, 20'hABCDE);
        quiet(); flip = 32'h8; tick(); flip = 0;
        lookup(5, 20'hABCDE);
        quiet(); flip = 32'h1 << 22; tick(); flip = 0;
        tick();

        // Flush colliding with an update and a lookup drops both.
        flush_req = 1; upd_req = 1; upd_set = 0; upd_tag = 20'h00001; upd_valid = 1;
        lkp_req = 1; lkp_set = 127; lkp_tag = 20'hFFFFF;
        tick();
        quiet();
        for (int i = 0; i < SETS; i++) tick();
        lookup(0, 20'h00001);
        lookup(127, 20'hFFFFF);
        quiet(); tc = 1; teh = 0; ted = 0; tet = 0; tick();
        quiet();

        // Reset in the middle of a sweep restarts it from set 0.
        upd_req = 1; upd_set = 60; upd_tag = 20'h0BEEF; upd_valid = 1; upd_dirty = 0; tick();
        quiet(); flush_req = 1; tick();
        quiet();
        for (int i = 0; i < 60; i++) tick();
        rst = 1; tick();
        quiet();
        for (int i = 0; i < SETS; i++) tick();
        lookup(60, 20'h0BEEF);

        for (int i = 0; i < 3000; i++) begin
            int s;
            quiet();
            s = $urandom_range(0, 7);
            flush_req = $urandom_range(0, 299) == 0;
            upd_req = $urandom_range(0, 3) == 0;
            upd_set = 7'(s < 4 ? s : 120 + s);
            upd_tag = 20'($urandom_range(0, 3) * 20'h33333);
            upd_valid = $urandom_range(0, 1); upd_dirty = $urandom_range(0, 1);
            s = $urandom_range(0, 7);
            lkp_req = $urandom_range(0, 1);
            lkp_set = 7'(s < 4 ? s : 120 + s);
            lkp_tag = 20'($urandom_range(0, 3) * 20'h33333);
            flip = $urandom_range(0, 49) == 0 ? 32'h1 << $urandom_range(0, 22) : 0;
            tick();
        end
        flip = 0;
        quiet(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_tag_ctrl.md
Name: dcache_tag_ctrl

Overview:
- Control stage directly upstream of the data-cache tag RAM. It drives that RAM's req/wr_en/addr/wdata and consumes its rdata.
- Performs three jobs:
  - invalidation sweep after reset and on flush;
  - single-cycle tag writes (updates);
  - pipelined lookups with tag compare, producing hit, dirty and the stored tag to the dcache FSM.
- Entry layout in the RAM word:
  - [TAG_WIDTH-1:0] = tag
  - [TAG_WIDTH] = valid
  - [TAG_WIDTH+1] = dirty
  - all remaining bits = 0

Parameters:
- SET_WIDTH, 7: set-index width; sets = 2**SET_WIDTH.
- TAG_WIDTH, 20: tag width; must satisfy TAG_WIDTH+3 <= DATA_WIDTH.
- NUM_COL, 4: RAM byte-column count.
- COL_WIDTH, 8: column width in bits.
- DATA_WIDTH, NUM_COL*COL_WIDTH: RAM word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_req  in  1  pulse; invalidate all sets.
- busy  out  1  high while sweeping.
- lkp_req  in  1  lookup request.
- lkp_ready  out  1  lookup accepted when lkp_req & lkp_ready.
- lkp_set  in  SET_WIDTH  lookup set index.
- lkp_tag  in  TAG_WIDTH  lookup tag.
- rsp_valid  out  1  lookup result valid.
- rsp_hit  out  1  valid & tag match.
- rsp_dirty  out  1  stored dirty bit.
- rsp_tag  out  TAG_WIDTH  stored tag (victim address).
- upd_req  in  1  tag write request, always accepted unless busy.
- upd_set  in  SET_WIDTH  write set index.
- upd_tag  in  TAG_WIDTH  write tag.
- upd_valid  in  1  valid bit to write.
- upd_dirty  in  1  dirty bit to write.
- par_err  out  1  parity error pulse (optional feature).
- ram_req  out  1  RAM request.
- ram_wr_en  out  NUM_COL  RAM column write enables.
- ram_addr  out  SET_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, one cycle after address.

Behaviour:

States:
- SWEEP: rst enters SWEEP with counter=0; rst wins over everything, including mid-sweep, where the counter restarts at 0.
- IDLE.

SWEEP:
- Each cycle drives ram_req=1, ram_wr_en=all ones, ram_addr=counter, ram_wdata=0.
- Counter increments each cycle.
- At counter = 2**SET_WIDTH-1: write that set, counter wraps to 0, next state IDLE.
- Duration: exactly 2**SET_WIDTH cycles.
- busy=1, lkp_ready=0; upd_req and flush_req are ignored (dropped).

IDLE:
- flush_req=1: next state SWEEP, counter=0. A flush in the same cycle as upd_req/lkp_req drops both requests.
- upd_req=1: ram_wr_en=all ones, ram_addr=upd_set, ram_wdata per layout. lkp_ready=0 that cycle, so update has priority over lookup.
- Otherwise: lkp_ready=1; ram_addr=lkp_set, ram_wr_en=0, ram_req=lkp_req.

Lookup pipeline:
- Accepted in cycle T. The lookup tag and a pending flag are registered.
- In T+1, rsp_valid=1 for exactly one cycle:
  - rsp_hit = ram_rdata[TAG_WIDTH] & (ram_rdata[TAG_WIDTH-1:0] == registered tag)
  - rsp_dirty = ram_rdata[TAG_WIDTH+1]
  - rsp_tag = ram_rdata[TAG_WIDTH-1:0]
- rsp outputs are combinational from ram_rdata and the registered tag.
- Back-to-back lookups sustain one per cycle.
- An update in T+1 does not corrupt the T response (the RAM already returned T data).
- An update in T followed by a lookup of the same set in T+1 returns the new data.

Outputs under reset and when not valid:
- Reset values: rsp_valid=0, busy=1, par_err=0, pending flag=0.
- When rsp_valid=0: rsp_hit, rsp_dirty and rsp_tag are 0.

Optional Feature:
DCACHE_TAG_PARITY_EN:
- Defined:
  - Bit [TAG_WIDTH+2] stores even parity over {dirty, valid, tag} on every update; the sweep writes 0, which is valid parity for an all-zero entry.
  - On a lookup response, a parity mismatch forces rsp_hit=0 and pulses par_err=1 with rsp_valid.
- Undefined:
  - Bit [TAG_WIDTH+2] is written 0 and ignored on reads.
  - par_err is tied 0.

Test Plan:
- Release rst → busy=1 for exactly 128 cycles, ram_addr runs 0..127 with wdata=0, then busy=0 and lkp_ready=1.
- Update set 5 with tag 0xABCDE, valid=1, dirty=1; lookup set 5 with tag 0xABCDE next cycle → rsp_valid, rsp_hit=1, rsp_dirty=1, rsp_tag=0xABCDE.
- Lookup set 5 with tag 0x12345 → rsp_hit=0, rsp_tag=0xABCDE (victim).
- upd_req and lkp_req in the same cycle → lkp_ready=0, update written; lookup accepted the next cycle.
- flush_req after populating sets 0/127 → 128-cycle sweep; later lookups of sets 0/127 → rsp_hit=0. Assert rst at sweep counter 60 → sweep restarts from 0.
- (DCACHE_TAG_PARITY_EN) Force ram_rdata bit 3 flipped on a hit → rsp_hit=0, par_err=1 for one cycle.
